// File: rtl/ov7670_emulator.sv
// ============================================================================
// Module   : ov7670_emulator
// Purpose  : Replays frames from an external frame buffer as an OV7670-style
//            camera stream: 640 bytes per line (two bytes per RGB565 pixel,
//            high byte first), 320x240 pixels, with programmable vertical and
//            horizontal blanking. Frames are generated back to back while en
//            is high; en is only examined at frame boundaries.
// Revision : 1.0 - initial release
//
// Optional feature macro: OV_EMU_PATTERN_EN
//   When defined, a pattern_sel input is added. If pattern_sel is high at the
//   start of a frame, that frame shows 8 vertical colour bars instead of
//   buffer contents, and the frame buffer is not read.
//
// Parameters
//   H_BLANK      : href-low pclk cycles after each 640-byte line
//   VSYNC_LINES  : line periods with v_sync high
//   VBP_LINES    : blank line periods between v_sync and the first active line
//   VFP_LINES    : blank line periods after the last active line
//   ACTIVE_LINES : active lines per frame (240 for a real QVGA frame; smaller
//                  values only shorten the frame for bring-up)
//
// Ports
//   pclk        in   pixel clock, all logic on the rising edge
//   reset       in   asynchronous, active-high reset
//   en          in   frame-generation enable (sampled at frame boundary)
//   pattern_sel in   colour-bar select (only with OV_EMU_PATTERN_EN)
//   rd_en       out  frame-buffer read strobe, one per pixel
//   rAddr       out  frame-buffer read address, line*320 + pixel
//   rData       in   RGB565 word, valid one pclk after rd_en
//   v_sync      out  active-high vertical sync
//   href        out  active-high line valid
//   ov7670_data out  byte stream, 0 while href is low
//   frame_done  out  one-pclk pulse in the last cycle of each frame
// ============================================================================
`default_nettype none

module ov7670_emulator #(
  parameter int H_BLANK      = 144,
  parameter int VSYNC_LINES  = 3,
  parameter int VBP_LINES    = 17,
  parameter int VFP_LINES    = 10,
  parameter int ACTIVE_LINES = 240
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        en,
`ifdef OV_EMU_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        rd_en,
  output logic [16:0] rAddr,
  input  logic [15:0] rData,
  output logic        v_sync,
  output logic        href,
  output logic [7:0]  ov7670_data,
  output logic        frame_done
);

  localparam int LINE_LEN = 640 + H_BLANK;
  localparam int H_W      = $clog2(LINE_LEN);

  localparam int MAX_A = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int MAX_B = (VFP_LINES > ACTIVE_LINES) ? VFP_LINES : ACTIVE_LINES;
  localparam int MAX_L = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int L_W   = (MAX_L > 1) ? $clog2(MAX_L) : 1;

  localparam logic [H_W-1:0] H_LAST   = H_W'(LINE_LEN - 1);
  localparam logic [H_W-1:0] H_PRE    = H_W'(LINE_LEN - 2);
  localparam logic [H_W-1:0] H_ACTIVE = H_W'(640);
  // Reads inside a line happen at even byte positions 0..636 (pixels 1..319);
  // pixel 0 is read two cycles before the line starts.
  localparam logic [H_W-1:0] H_RD_END = H_W'(638);

  localparam logic [L_W-1:0] VS_LAST  = L_W'(VSYNC_LINES - 1);
  localparam logic [L_W-1:0] VBP_LAST = L_W'(VBP_LINES - 1);
  localparam logic [L_W-1:0] ACT_LAST = L_W'(ACTIVE_LINES - 1);
  localparam logic [L_W-1:0] VFP_LAST = L_W'(VFP_LINES - 1);

  localparam logic [16:0] ADDR_LAST = 17'(ACTIVE_LINES * 320 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBP    = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFP    = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [H_W-1:0] h_q, h_d;
  logic [L_W-1:0] ln_q, ln_d;
  logic [L_W-1:0] ln_end;

  logic           v_sync_q, v_sync_d;
  logic           href_q, href_d;
  logic           rd_en_q, rd_en_d;
  logic           rd_dly_q;
  logic           fd_q, fd_d;
  logic [16:0]    addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic [7:0]     lo_q, lo_d;
  logic           next_active;
  logic           pattern_on;

`ifdef OV_EMU_PATTERN_EN
  logic           pat_q, pat_d;
  logic [15:0]    bar;

  // Colour of the bar containing byte position hpos (80 bytes = 40 pixels).
  function automatic logic [15:0] bar_colour(input logic [H_W-1:0] hpos);
    logic [15:0] c;
    if      (hpos < H_W'(80))  c = 16'hFFFF;
    else if (hpos < H_W'(160)) c = 16'hFFE0;
    else if (hpos < H_W'(240)) c = 16'h07FF;
    else if (hpos < H_W'(320)) c = 16'h07E0;
    else if (hpos < H_W'(400)) c = 16'hF81F;
    else if (hpos < H_W'(480)) c = 16'hF800;
    else if (hpos < H_W'(560)) c = 16'h001F;
    else                       c = 16'h0000;
    return c;
  endfunction

  assign pattern_on = pat_q;
`else
  assign pattern_on = 1'b0;
`endif

  // Last line index of the current vertical phase.
  always_comb begin
    case (state_q)
      S_VSYNC:  ln_end = VS_LAST;
      S_VBP:    ln_end = VBP_LAST;
      S_ACTIVE: ln_end = ACT_LAST;
      default:  ln_end = VFP_LAST;
    endcase
  end

  // Frame timing: byte counter within the line, line counter within the
  // current phase, and phase sequencing.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    ln_d    = ln_q;
    case (state_q)
      S_IDLE: begin
        h_d  = '0;
        ln_d = '0;
        if (en) state_d = S_VSYNC;
      end
      S_VSYNC, S_VBP, S_ACTIVE, S_VFP: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (ln_q == ln_end) begin
            ln_d = '0;
            case (state_q)
              S_VSYNC:  state_d = S_VBP;
              S_VBP:    state_d = S_ACTIVE;
              S_ACTIVE: state_d = S_VFP;
              default:  state_d = en ? S_VSYNC : S_IDLE;
            endcase
          end else begin
            ln_d = ln_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        h_d     = '0;
        ln_d    = '0;
      end
    endcase
  end

`ifdef OV_EMU_PATTERN_EN
  // Pattern choice is frozen for the whole frame at VSYNC entry.
  always_comb begin
    pat_d = pat_q;
    if (state_d == S_VSYNC && state_q != S_VSYNC) pat_d = pattern_sel;
  end
  assign bar = bar_colour(h_d);
`endif

  // Every output register is loaded with the value belonging to the cycle the
  // counters are about to enter, so outputs line up with the counters while
  // staying fully registered.
  always_comb begin
    v_sync_d = (state_d == S_VSYNC);
    href_d   = (state_d == S_ACTIVE) && (h_d < H_ACTIVE);
    fd_d     = (state_d == S_VFP) && (ln_d == VFP_LAST) && (h_d == H_LAST);

    // The line following the current one carries pixels.
    next_active = ((state_d == S_VBP) && (ln_d == VBP_LAST)) ||
                  ((state_d == S_ACTIVE) && (ln_d != ACT_LAST));

    rd_en_d = 1'b0;
    if (!pattern_on) begin
      if ((state_d == S_ACTIVE) && (h_d < H_RD_END) && !h_d[0]) rd_en_d = 1'b1;
      if ((h_d == H_PRE) && next_active)                       rd_en_d = 1'b1;
    end

    if (state_q == S_IDLE)        addr_d = '0;
    else if (rd_en_q)             addr_d = (addr_q == ADDR_LAST) ? 17'd0 : addr_q + 17'd1;
    else                          addr_d = addr_q;

    // rData is valid in the cycle after a strobe: its high byte goes straight
    // to the output register, its low byte is held for the following cycle.
    lo_d   = rd_dly_q ? rData[7:0] : lo_q;
    data_d = rd_dly_q ? rData[15:8] : (href_d ? lo_q : 8'h00);
`ifdef OV_EMU_PATTERN_EN
    if (pat_q) data_d = href_d ? (h_d[0] ? bar[7:0] : bar[15:8]) : 8'h00;
`endif
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      h_q      <= '0;
      ln_q     <= '0;
      v_sync_q <= 1'b0;
      href_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_dly_q <= 1'b0;
      fd_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      ln_q     <= ln_d;
      v_sync_q <= v_sync_d;
      href_q   <= href_d;
      rd_en_q  <= rd_en_d;
      rd_dly_q <= rd_en_q;
      fd_q     <= fd_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      lo_q     <= lo_d;
    end
  end

`ifdef OV_EMU_PATTERN_EN
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) pat_q <= 1'b0;
    else       pat_q <= pat_d;
  end
`endif

  assign rd_en       = rd_en_q;
  assign rAddr       = addr_q;
  assign v_sync      = v_sync_q;
  assign href        = href_q;
  assign ov7670_data = data_q;
  assign frame_done  = fd_q;

endmodule

`default_nettype wire
